// File: rtl/led_pkg.sv
// Shared types and constants for the LED matrix scan engine and
// the game-side display helpers.
package led_pkg;

    localparam int MAX_BPP = 4;

    // Row drivers are active-low.
    localparam logic ON  = 1'b0;
    localparam logic OFF = 1'b1;

    typedef struct packed {
        logic [MAX_BPP-1:0] r;
        logic [MAX_BPP-1:0] g;
        logic [MAX_BPP-1:0] b;
    } rgb_t;

    // Splits a packed {R,G,B} word of bpp bits per channel.
    function automatic rgb_t unpack_rgb(
        input logic [3*MAX_BPP-1:0] v,
        input int unsigned          bpp
    );
        rgb_t               p;
        logic [MAX_BPP-1:0] m;
        m   = MAX_BPP'((1 << bpp) - 1);
        p.r = MAX_BPP'(v >> (2 * bpp)) & m;
        p.g = MAX_BPP'(v >> bpp) & m;
        p.b = MAX_BPP'(v) & m;
        return p;
    endfunction

    // Hex glyphs, segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Back-buffer pixel write port and frame swap handshake.
interface led_matrix_scanner_if #(
    parameter int COLS = 8,
    parameter int ROWS = 8,
    parameter int BPP  = 2
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic             wr_en;
    logic [CW-1:0]    wr_col;
    logic [RW-1:0]    wr_row;
    logic [3*BPP-1:0] wr_rgb;
    logic             swap_req;
    logic             swap_ack;

    modport master (
        output wr_en, wr_col, wr_row, wr_rgb, swap_req,
        input  swap_ack
    );

    modport slave (
        input  wr_en, wr_col, wr_row, wr_rgb, swap_req,
        output swap_ack
    );

endinterface

// File: rtl/scan_prescaler.sv
// Free-running divider; tick_o is high in the last cycle of each period.
module scan_prescaler #(
    parameter int DIV = 8
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick_o
);
    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == W'(DIV - 1));
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered RGB matrix scanner with PWM slots, blanking and
// tear-free swap; outputs trail the scan counters by one cycle.
module led_matrix_scanner
    import led_pkg::*;
#(
    parameter int COLS      = 8,
    parameter int ROWS      = 8,
    parameter int BPP       = 2,
    parameter int CLK_HZ    = 50_000_000,
    parameter int COL_HZ    = 8000,
    parameter int BLANK_CYC = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    led_matrix_scanner_if.slave      bus,
    input  logic                     blank,
    output logic [ROWS-1:0]          DATA_R,
    output logic [ROWS-1:0]          DATA_G,
    output logic [ROWS-1:0]          DATA_B,
    output logic [$clog2(COLS)-1:0]  COMM,
    output logic                     enable,
    output logic                     frame_start
);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int SLOTS = 2**BPP - 1;
    localparam int DIV   = CLK_HZ / (COL_HZ * SLOTS);
    localparam int BW    = $clog2(BLANK_CYC + 2);

    if (DIV < 2 || BLANK_CYC >= DIV || BPP < 1 || BPP > MAX_BPP)
    begin : g_bad_cfg
        $error("led_matrix_scanner: bad DIV/BLANK_CYC/BPP");
    end

    logic tick;

    scan_prescaler #(.DIV(DIV)) u_presc (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .tick_o (tick)
    );

    rgb_t            mem_q [2][COLS][ROWS];
    rgb_t            px;
    logic [BPP-1:0]  slot_q, slot_d;
    logic [CW-1:0]   col_q, col_d, comm_q;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic            front_q, front_d, pend_q, pend_d;
    logic            ack_q, en_q, fs_q, fs_d;
    logic [ROWS-1:0] dr_q, dg_q, db_q, dr_d, dg_d, db_d;
    logic            slot_wrap, col_wrap, do_swap, wr_ok;

    assign slot_wrap = tick && (slot_q == BPP'(SLOTS - 1));
    assign col_wrap  = slot_wrap && (col_q == CW'(COLS - 1));
    assign do_swap   = col_wrap && (pend_q || bus.swap_req);
    assign wr_ok     = bus.wr_en
                    && ({1'b0, bus.wr_col} < (CW+1)'(COLS))
                    && ({1'b0, bus.wr_row} < (RW+1)'(ROWS));

    assign slot_d  = !tick      ? slot_q
                   : slot_wrap  ? '0 : slot_q + 1'b1;
    assign col_d   = !slot_wrap ? col_q
                   : col_wrap   ? '0 : col_q + 1'b1;
    assign bcnt_d  = slot_wrap        ? BW'(BLANK_CYC)
                   : (bcnt_q != '0)   ? bcnt_q - 1'b1 : '0;
    assign front_d = front_q ^ do_swap;
    assign pend_d  = !do_swap && (pend_q || bus.swap_req);
    assign fs_d    = (col_q == '0) && (comm_q == CW'(COLS - 1));

    // A channel is lit while its intensity exceeds the current PWM slot.
    always_comb begin
        dr_d = '1;
        dg_d = '1;
        db_d = '1;
        px   = '0;
        if (!blank && bcnt_q == '0) begin
            for (int r = 0; r < ROWS; r++) begin
                px      = mem_q[front_q][col_q][r];
                dr_d[r] = (px.r > MAX_BPP'(slot_q)) ? ON : OFF;
                dg_d[r] = (px.g > MAX_BPP'(slot_q)) ? ON : OFF;
                db_d[r] = (px.b > MAX_BPP'(slot_q)) ? ON : OFF;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_q  <= '0;
            col_q   <= '0;
            bcnt_q  <= '0;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            en_q    <= 1'b0;
            fs_q    <= 1'b0;
            comm_q  <= '0;
            dr_q    <= '1;
            dg_q    <= '1;
            db_q    <= '1;
        end else begin
            slot_q  <= slot_d;
            col_q   <= col_d;
            bcnt_q  <= bcnt_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            ack_q   <= do_swap;
            en_q    <= 1'b1;
            fs_q    <= fs_d;
            comm_q  <= col_q;
            dr_q    <= dr_d;
            dg_q    <= dg_d;
            db_q    <= db_d;
        end
    end

    // Writes always target the bank not being displayed at this edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < COLS; c++)
                    for (int r = 0; r < ROWS; r++)
                        mem_q[b][c][r] <= '0;
        end else if (wr_ok) begin
            mem_q[!front_q][bus.wr_col][bus.wr_row] <=
                unpack_rgb((3*MAX_BPP)'(bus.wr_rgb), BPP);
        end
    end

    assign DATA_R       = dr_q;
    assign DATA_G       = dg_q;
    assign DATA_B       = db_q;
    assign COMM         = comm_q;
    assign enable       = en_q;
    assign frame_start  = fs_q;
    assign bus.swap_ack = ack_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomised scoreboard bench for led_matrix_scanner; a frame-level
// reference model predicts the full output word for every cycle.
module tb_led_matrix_scanner;

    localparam int COLS      = 8;
    localparam int ROWS      = 8;
    localparam int BPP       = 2;
    localparam int DIV       = 8;
    localparam int SLOTS     = 3;
    localparam int BLANK_CYC = 2;
    localparam int CPC       = DIV * SLOTS;
    localparam int FRAME     = CPC * COLS;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [2:0] comm;
        logic       en;
        logic       fs;
        logic       ack;
    } exp_t;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       blank = 1'b0;
    logic [7:0] DATA_R, DATA_G, DATA_B;
    logic [2:0] COMM;
    logic       enable, frame_start;

    led_matrix_scanner_if #(.COLS(COLS), .ROWS(ROWS), .BPP(BPP)) bus ();

    led_matrix_scanner #(
        .COLS(COLS), .ROWS(ROWS), .BPP(BPP),
        .CLK_HZ(24), .COL_HZ(1), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bus         (bus),
        .blank       (blank),
        .DATA_R      (DATA_R),
        .DATA_G      (DATA_G),
        .DATA_B      (DATA_B),
        .COMM        (COMM),
        .enable      (enable),
        .frame_start (frame_start)
    );

    always #5 CLK = ~CLK;

    int   front_img [COLS][ROWS][3];
    int   back_img  [COLS][ROWS][3];
    bit   pend;
    int   cyc;
    exp_t exp_q [$];
    exp_t got_e;
    int   total = 0;
    int   bad   = 0;

    // Frame-level model: column/slot follow from elapsed cycles.
    task automatic model_step();
        exp_t       e;
        int         k, col, slot;
        int         t [COLS][ROWS][3];
        bit         sw, off;
        logic [5:0] v;
        cyc++;
        k    = cyc - 1;
        col  = (k / CPC) % COLS;
        slot = (k / DIV) % SLOTS;
        off  = blank || ((k % CPC) < BLANK_CYC);
        for (int r = 0; r < ROWS; r++) begin
            e.r[r] = (!off && front_img[col][r][0] > slot) ? 1'b0 : 1'b1;
            e.g[r] = (!off && front_img[col][r][1] > slot) ? 1'b0 : 1'b1;
            e.b[r] = (!off && front_img[col][r][2] > slot) ? 1'b0 : 1'b1;
        end
        e.comm = 3'(col);
        e.en   = 1'b1;
        e.fs   = (k > 0) && (k % FRAME == 0);
        sw     = (cyc % FRAME == 0) && (pend || bus.swap_req);
        e.ack  = sw;
        exp_q.push_back(e);
        if (bus.wr_en) begin
            v = bus.wr_rgb;
            back_img[bus.wr_col][bus.wr_row][0] = int'(v[5:4]);
            back_img[bus.wr_col][bus.wr_row][1] = int'(v[3:2]);
            back_img[bus.wr_col][bus.wr_row][2] = int'(v[1:0]);
        end
        if (sw) begin
            t         = front_img;
            front_img = back_img;
            back_img  = t;
            pend      = 1'b0;
        end else begin
            pend = pend || bus.swap_req;
        end
    endtask

    task automatic model_reset();
        exp_t e;
        exp_q.delete();
        e.r    = 8'hFF;
        e.g    = 8'hFF;
        e.b    = 8'hFF;
        e.comm = 3'd0;
        e.en   = 1'b0;
        e.fs   = 1'b0;
        e.ack  = 1'b0;
        exp_q.push_back(e);
        foreach (front_img[c, r, ch]) begin
            front_img[c][r][ch] = 0;
            back_img[c][r][ch]  = 0;
        end
        pend = 1'b0;
        cyc  = 0;
    endtask

    initial forever begin
        @(posedge CLK or negedge RST_N);
        if (!RST_N) model_reset();
        else        model_step();
    end

    initial forever begin
        @(negedge CLK);
        if (exp_q.size() > 0) begin
            got_e = exp_q.pop_front();
            total++;
            if ({DATA_R, DATA_G, DATA_B, COMM, enable, frame_start,
                 bus.swap_ack} !==
                {got_e.r, got_e.g, got_e.b, got_e.comm, got_e.en,
                 got_e.fs, got_e.ack}) begin
                bad++;
                $display({"FAIL scan cyc=%0d got R=%h G=%h B=%h COMM=%0d",
                          " en=%b fs=%b ack=%b want R=%h G=%h B=%h",
                          " COMM=%0d en=%b fs=%b ack=%b"},
                         cyc, DATA_R, DATA_G, DATA_B, COMM, enable,
                         frame_start, bus.swap_ack, got_e.r, got_e.g,
                         got_e.b, got_e.comm, got_e.en, got_e.fs,
                         got_e.ack);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wr(input int c, input int r, input logic [5:0] rgb);
        @(negedge CLK);
        bus.wr_en  = 1'b1;
        bus.wr_col = 3'(c);
        bus.wr_row = 3'(r);
        bus.wr_rgb = rgb;
        @(negedge CLK);
        bus.wr_en  = 1'b0;
    endtask

    task automatic swap_pulse();
        @(negedge CLK);
        bus.swap_req = 1'b1;
        @(negedge CLK);
        bus.swap_req = 1'b0;
    endtask

    // Returns at the negedge where the model cycle count hits ph.
    task automatic wait_phase(input int ph);
        @(negedge CLK);
        repeat (FRAME) begin
            if (cyc % FRAME == ph) break;
            @(negedge CLK);
        end
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_col   = '0;
        bus.wr_row   = '0;
        bus.wr_rgb   = '0;
        bus.swap_req = 1'b0;
        blank        = 1'b0;
        RST_N        = 1'b0;
        idle(3);
        RST_N = 1'b1;

        wr(3, 5, 6'b11_01_00);
        swap_pulse();
        idle(3 * FRAME);

        wr(6, 2, 6'b10_11_01);
        idle(3 * FRAME);

        wait_phase(FRAME - 1);
        bus.wr_en    = 1'b1;
        bus.wr_col   = 3'd0;
        bus.wr_row   = 3'd0;
        bus.wr_rgb   = 6'b00_11_00;
        bus.swap_req = 1'b1;
        @(negedge CLK);
        bus.wr_en    = 1'b0;
        bus.swap_req = 1'b0;
        idle(FRAME);

        wait_phase(FRAME - 1);
        blank        = 1'b1;
        bus.swap_req = 1'b1;
        @(negedge CLK);
        bus.swap_req = 1'b0;
        idle(FRAME);
        blank = 1'b0;
        idle(FRAME / 2);

        repeat (4 * FRAME) begin
            @(negedge CLK);
            bus.wr_en    = ($urandom_range(0, 2) == 0);
            bus.wr_col   = 3'($urandom_range(0, 7));
            bus.wr_row   = 3'($urandom_range(0, 7));
            bus.wr_rgb   = 6'($urandom);
            bus.swap_req = ($urandom_range(0, 149) == 0);
            blank        = ($urandom_range(0, 39) == 0);
        end
        @(negedge CLK);
        bus.wr_en    = 1'b0;
        bus.swap_req = 1'b0;
        blank        = 1'b0;

        wait_phase(CPC);
        repeat (10) wr($urandom_range(0, 7), $urandom_range(0, 7),
                       6'($urandom | 1));
        swap_pulse();
        wait_phase(4 * CPC + 5);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        idle(3);
        RST_N = 1'b1;
        idle(FRAME);
        swap_pulse();
        idle(FRAME + CPC);
        swap_pulse();
        idle(FRAME + CPC);
        idle(2);

        total++;
        if (total < 2500) begin
            bad++;
            $display("FAIL coverage checks=%0d need>=2500", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
